// File: rtl/sm_addsub_pkg.sv
// Shared types for the sign-magnitude add/sub pipeline.
// The stage payload structs fix the datapath width at SM_WIDTH.
package sm_addsub_pkg;

  localparam int SM_WIDTH = 16;
  localparam int SM_TAG_W = 4;
  localparam int RES_W    = SM_WIDTH + 1;

  typedef struct packed {
    logic                a_sign;
    logic                b_sign;
    logic [SM_WIDTH-1:0] a_mag;
    logic [SM_WIDTH-1:0] b_mag;
    logic                eff_sub;
    logic                a_ge_b;
    logic                b_eff;
  } s1_payload_t;

  typedef struct packed {
    logic             sign;
    logic [RES_W-1:0] mag;
    logic             zero;
    logic             eff_sub;
  } s2_payload_t;

endpackage

// File: rtl/sm_addsub_stage.sv
// Generic valid/ready pipeline register with synchronous flush and async active-low reset.
module sm_addsub_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Flush wins over any capture; the data register only loads with a real beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude add/subtract core with valid/ready backpressure and flush.
// Define SM_ADDSUB_TAG_EN to carry an in_tag/out_tag sideband alongside each beat.
module sm_addsub_pipe
  import sm_addsub_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH,
  parameter int TAG_W = SM_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
`ifdef SM_ADDSUB_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH:0]   out_mag,
  output logic             out_zero,
  output logic             out_eff_sub
);

  s1_payload_t s1_in, s1_q;
  s2_payload_t s2_in, s2_q;
  logic        s1_valid;
  logic        s2_in_ready;
  logic        in_b_eff;

  assign in_b_eff       = b_sign ^ op_sub;
  assign s1_in.a_sign   = a_sign;
  assign s1_in.b_sign   = b_sign;
  assign s1_in.a_mag    = a_mag;
  assign s1_in.b_mag    = b_mag;
  assign s1_in.eff_sub  = a_sign ^ in_b_eff;
  assign s1_in.a_ge_b   = (a_mag >= b_mag);
  assign s1_in.b_eff    = in_b_eff;

  // Larger magnitude minus smaller; an exact cancellation always yields +0.
  always_comb begin
    s2_in         = '0;
    s2_in.eff_sub = s1_q.eff_sub;
    if (!s1_q.eff_sub) begin
      s2_in.mag  = {1'b0, s1_q.a_mag} + {1'b0, s1_q.b_mag};
      s2_in.sign = s1_q.a_sign;
    end else if (s1_q.a_ge_b) begin
      s2_in.mag  = {1'b0, s1_q.a_mag - s1_q.b_mag};
      s2_in.sign = s1_q.a_sign && (s1_q.a_mag != s1_q.b_mag);
    end else begin
      s2_in.mag  = {1'b0, s1_q.b_mag - s1_q.a_mag};
      s2_in.sign = s1_q.b_eff;
    end
    s2_in.zero = (s2_in.mag == '0);
  end

`ifdef SM_ADDSUB_TAG_EN
  logic [TAG_W-1:0]                   s1_tag;
  logic [$bits(s1_payload_t)+TAG_W-1:0] s1_d, s1_qv;
  logic [$bits(s2_payload_t)+TAG_W-1:0] s2_d, s2_qv;
  assign s1_d            = {in_tag, s1_in};
  assign {s1_tag, s1_q}  = s1_qv;
  assign s2_d            = {s1_tag, s2_in};
  assign {out_tag, s2_q} = s2_qv;
`else
  logic [$bits(s1_payload_t)-1:0] s1_d, s1_qv;
  logic [$bits(s2_payload_t)-1:0] s2_d, s2_qv;
  assign s1_d = s1_in;
  assign s1_q = s1_qv;
  assign s2_d = s2_in;
  assign s2_q = s2_qv;
`endif

  sm_addsub_stage #(.DATA_W($bits(s1_d))) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_qv)
  );

  sm_addsub_stage #(.DATA_W($bits(s2_d))) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_qv)
  );

  assign out_sign    = s2_q.sign;
  assign out_mag     = s2_q.mag;
  assign out_zero    = s2_q.zero;
  assign out_eff_sub = s2_q.eff_sub;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed vector table, stall/flush/reset
// sequences, and randomized traffic checked against a signed-integer reference model.
module tb_sm_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        a_sign, b_sign;
  logic [15:0] a_mag, b_mag;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [16:0] out_mag;
  logic        out_zero;
  logic        out_eff_sub;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sign;
    logic [16:0] mag;
    logic        zero;
    logic        eff;
  } exp_t;

  typedef struct {
    string       name;
    logic        a_sign;
    logic [15:0] a_mag;
    logic        b_sign;
    logic [15:0] b_mag;
    logic        op_sub;
    logic        exp_sign;
    logic [16:0] exp_mag;
    logic        exp_zero;
    logic        exp_eff;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  sm_addsub_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_sign      (a_sign),
    .b_sign      (b_sign),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .op_sub      (op_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_mag     (out_mag),
    .out_zero    (out_zero),
    .out_eff_sub (out_eff_sub)
  );

  // Reference: evaluate the signed values as plain integers and read back sign and magnitude.
  function automatic exp_t model(logic as, logic [15:0] am, logic bs, logic [15:0] bm, logic sub);
    exp_t e;
    int   va, vb, r;
    logic be;
    be    = bs ^ sub;
    va    = as ? -int'(am) : int'(am);
    vb    = be ? -int'(bm) : int'(bm);
    r     = va + vb;
    e.eff = as ^ be;
    e.mag = 17'(r < 0 ? -r : r);
    if (r < 0)      e.sign = 1'b1;
    else if (r > 0) e.sign = 1'b0;
    else            e.sign = e.eff ? 1'b0 : as;
    e.zero = (r == 0);
    return e;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the core accepts it.
  task automatic applyStimulus(logic as, logic [15:0] am, logic bs, logic [15:0] bm, logic sub);
    bit ok = 0;
    a_sign = as; a_mag = am; b_sign = bs; b_mag = bm; op_sub = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard monitor: retire delivered beats, drop flushed ones, queue accepted ones.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL sb_unexpected: got mag 0x%0h sign %0b, expected no beat", out_mag, out_sign);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_mag !== e.mag || out_sign !== e.sign || out_zero !== e.zero || out_eff_sub !== e.eff) begin
            n_fail++;
            $display("[TB] FAIL sb_beat: got mag 0x%0h sign %0b zero %0b eff %0b, expected mag 0x%0h sign %0b zero %0b eff %0b",
                     out_mag, out_sign, out_zero, out_eff_sub, e.mag, e.sign, e.zero, e.eff);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(a_sign, a_mag, b_sign, b_mag, op_sub));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [16:0] hold_mag;
    logic        hold_sign;

    vecs[0] = '{"add_basic",  1'b0, 16'h1234, 1'b0, 16'h0F00, 1'b0, 1'b0, 17'h02134, 1'b0, 1'b0};
    vecs[1] = '{"sub_swap",   1'b0, 16'h0100, 1'b0, 16'h0300, 1'b1, 1'b1, 17'h00200, 1'b0, 1'b1};
    vecs[2] = '{"cancel",     1'b1, 16'h0050, 1'b0, 16'h0050, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b1};
    vecs[3] = '{"negzero",    1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 17'h00000, 1'b1, 1'b0};
    vecs[4] = '{"carry",      1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFE, 1'b0, 1'b0};
    vecs[5] = '{"neg_add",    1'b1, 16'h0300, 1'b0, 16'h0100, 1'b1, 1'b1, 17'h00400, 1'b0, 1'b0};
    vecs[6] = '{"sub_negneg", 1'b0, 16'h0005, 1'b1, 16'h0010, 1'b1, 1'b0, 17'h00015, 1'b0, 1'b0};
    vecs[7] = '{"neg_sub",    1'b1, 16'h0200, 1'b1, 16'h0050, 1'b1, 1'b1, 17'h001B0, 1'b0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_sign = 1'b0; b_sign = 1'b0; a_mag = '0; b_mag = '0; op_sub = 1'b0;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_mag",   32'(out_mag),   32'd0);
    checkOutput("rst_out_sign",  32'(out_sign),  32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      a_sign = vecs[i].a_sign; a_mag = vecs[i].a_mag; b_sign = vecs[i].b_sign;
      b_mag = vecs[i].b_mag; op_sub = vecs[i].op_sub; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput({vecs[i].name, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({vecs[i].name, "_valid"}, 32'(out_valid),   32'd1);
      checkOutput({vecs[i].name, "_mag"},   32'(out_mag),     32'(vecs[i].exp_mag));
      checkOutput({vecs[i].name, "_sign"},  32'(out_sign),    32'(vecs[i].exp_sign));
      checkOutput({vecs[i].name, "_zero"},  32'(out_zero),    32'(vecs[i].exp_zero));
      checkOutput({vecs[i].name, "_eff"},   32'(out_eff_sub), 32'(vecs[i].exp_eff));
    end

    $display("[TB] backpressure stall");
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(1'b0, 16'h0011, 1'b0, 16'h0022, 1'b0);
    applyStimulus(1'b1, 16'h0100, 1'b0, 16'h0040, 1'b0);
    a_sign = 1'b0; a_mag = 16'h0333; b_sign = 1'b1; b_mag = 16'h0111; op_sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
    checkOutput("stall_valid",    32'(out_valid), 32'd1);
    checkOutput("stall_mag",      32'(out_mag),   32'h33);
    hold_mag = out_mag; hold_sign = out_sign;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_mag",  32'(out_mag),  32'(hold_mag));
      checkOutput("stall_hold_sign", 32'(out_sign), 32'(hold_sign));
      checkOutput("stall_hold_rdy",  32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0333, 1'b1, 16'h0111, 1'b1);
    applyStimulus(1'b1, 16'h0007, 1'b1, 16'h0009, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_drained", 32'(sb.size()), 32'd0);

    $display("[TB] flush");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h1000, 1'b0, 16'h0001, 1'b0);
    applyStimulus(1'b0, 16'h2000, 1'b0, 16'h0002, 1'b0);
    a_sign = 1'b0; a_mag = 16'h3000; b_sign = 1'b0; b_mag = 16'h0003; op_sub = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("flush_no_beats", 32'(sb.size()), 32'd0);

    $display("[TB] async reset mid-stream");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h00AA, 1'b0, 16'h0055, 1'b1);
    applyStimulus(1'b1, 16'h0F0F, 1'b1, 16'h00F0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_out_valid", 32'(out_valid),   32'd0);
    checkOutput("arst_out_mag",   32'(out_mag),     32'd0);
    checkOutput("arst_out_sign",  32'(out_sign),    32'd0);
    checkOutput("arst_out_eff",   32'(out_eff_sub), 32'd0);
    checkOutput("arst_in_ready",  32'(in_ready),    32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      a_sign    = 1'($urandom_range(0, 1));
      b_sign    = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      a_mag     = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b_mag = 16'($urandom);
        1: b_mag = a_mag;
        2: begin a_mag = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000; b_mag = 16'hFFFF; end
        default: b_mag = 16'($urandom_range(0, 15));
      endcase
    end
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("rand_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_addsub_pipe.md
# sm_addsub_pipe

Pipelined sign-magnitude add/subtract core for the FPU mantissa datapath. It takes two signed magnitudes and an add/sub opcode, then resolves the effective operation from the sign/opcode combination. It computes `|larger| ± |smaller|` and produces the result magnitude and sign. Output is registered through a two-stage valid/ready pipeline with backpressure and flush, and sits between the exponent-align stage and the normaliser.

## Interface
- `WIDTH`, default 16, magnitude width in bits; result is `WIDTH+1` bits.
- `TAG_W`, default 4, width of the optional sideband tag (see Configuration).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `flush`  input  1  synchronous pipeline clear.
- `in_valid`  input  1  operand beat valid.
- `in_ready`  output  1  core accepts a beat this cycle.
- `a_sign`, `b_sign`  input  1 each  operand signs (1 = negative).
- `a_mag`, `b_mag`  input  WIDTH each  operand magnitudes.
- `op_sub`  input  1  0 = A+B, 1 = A−B.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_sign`  output  1  result sign.
- `out_mag`  output  WIDTH+1  result magnitude; MSB is the carry of an effective add.
- `out_zero`  output  1  result magnitude is zero.
- `out_eff_sub`  output  1  an effective subtraction was performed.

## Operation
- `b_eff = b_sign ^ op_sub`; `eff_sub = a_sign ^ b_eff`.
- Stage 1 (S1) registers the operands, `eff_sub`, `a_ge_b = (a_mag >= b_mag)` and `b_eff`.
- Stage 2 (S2) computes the result:
  - Effective add: `out_mag = a_mag + b_mag` (zero-extended to WIDTH+1); `out_sign = a_sign`.
  - Effective sub, `a_ge_b`: `out_mag = a_mag − b_mag`; `out_sign = a_sign`.
  - Effective sub, `!a_ge_b`: `out_mag = b_mag − a_mag`; `out_sign = b_eff`.
  - Effective sub with equal magnitudes: `out_mag = 0`, `out_sign = 0` (+0).
  - Effective add of two zero magnitudes keeps `a_sign`, so −0 + −0 = −0.
- `out_zero = (out_mag == 0)`, registered together with the rest of the S2 payload.
- There is no wrap-around: the WIDTH+1 result always holds the full sum.

## Timing
- Latency is 2 cycles from an accepted input to `out_valid`, with no stalls.
- Throughput is 1 beat per cycle while `out_ready` stays high.
- Advance rules:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv` (combinational).
- A beat is accepted when `in_valid && in_ready`.
- While `out_valid && !out_ready`, all `out_*` hold stable. The stall back-propagates to `in_ready` in the same cycle.
- A simultaneous accept at S1 and drain at S2 is legal, and no bubble is inserted.
- `flush`:
  - Clears `s1_valid` and `s2_valid` at the next edge.
  - Overrides any capture in that cycle, so an input presented with `flush` is dropped.
  - `in_ready` is still driven by the advance rules during the flush cycle.
- Reset, including assertion mid-operation: all valids = 0 and all `out_*` = 0; in-flight beats are discarded.
- `in_ready` = 1 out of reset.

## Configuration
- `SM_ADDSUB_TAG_EN` defined:
  - Adds port `in_tag` (input, TAG_W) and port `out_tag` (output, TAG_W).
  - The tag is carried through both stages alongside its beat and obeys the same hold, flush and reset rules (reset value 0).
- `SM_ADDSUB_TAG_EN` undefined: the tag ports and tag registers do not exist; all other behaviour is identical.

## Structure
- `sm_addsub_pkg` holds:
  - the `s1_payload_t` struct (signs, magnitudes, `eff_sub`, `a_ge_b`, `b_eff`);
  - the `s2_payload_t` struct (sign, mag, zero, `eff_sub`);
  - the localparam `RES_W = WIDTH+1` convention.
- Sub-module `sm_addsub_stage`: a generic valid/ready pipeline register with flush and async reset, instantiated twice. Arithmetic stays in the top level.

## Test plan
1. WIDTH=16. `a=+0x1234`, `b=+0x0F00`, `op_sub=0` → after 2 cycles: `out_mag=0x02134`, `sign=0`, `eff_sub=0`.
2. `a=+0x0100`, `b=+0x0300`, `op_sub=1` → `out_mag=0x00200`, `sign=1`, `eff_sub=1`.
3. `a=−0x0050`, `b=+0x0050`, `op_sub=0` → `out_mag=0`, `zero=1`, `sign=0`. Separately, `a=−0`, `b=−0`, add → `zero=1`, `sign=1`.
4. `a=+0xFFFF`, `b=+0xFFFF`, add → `out_mag=0x1FFFE`, MSB set.
5. Stream 4 beats with `out_ready=0` from cycle 3 → `in_ready` falls once both stages are full and `out_*` stay constant. Releasing `out_ready` delivers all beats in order with none lost or duplicated.
6. Two beats in flight, then `flush` with `in_valid=1` → next cycle both valids are 0 and the flush-cycle beat never appears. Repeat with `rst_n` pulsed mid-stream → all outputs are 0 immediately (asynchronously).
